// File: rtl/controlador_vizinhos.sv
// Neighbour expansion sequencer: walks the 4/8 grid neighbours of a node, filters
// out-of-grid and corner-cutting candidates, reads the obstacle map and hands free cells on.
module controlador_vizinhos #(
    parameter int COORD_WIDTH = 6,
    parameter int GRID_X      = 64,
    parameter int GRID_Y      = 64,
    parameter int ADDR_WIDTH  = 12,
    parameter int DIAGONAL    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   expandir_in,
    input  logic [COORD_WIDTH-1:0] no_x_in,
    input  logic [COORD_WIDTH-1:0] no_y_in,
    output logic                   ocupado_out,
    output logic                   mem_req_out,
    output logic [ADDR_WIDTH-1:0]  mem_addr_out,
    input  logic                   mem_ack_in,
    input  logic                   mem_obstaculo_in,
    output logic                   viz_valido_out,
    output logic [COORD_WIDTH-1:0] viz_x_out,
    output logic [COORD_WIDTH-1:0] viz_y_out,
    output logic                   viz_diagonal_out,
    input  logic                   viz_aceito_in,
    output logic                   lvv_pronto_out
);

    typedef enum logic [2:0] {
        IDLE,
        GERAR,
        LER,
        ENTREGAR,
        PROXIMO,
        PRONTO
    } estado_t;

    localparam logic [2:0] K_ULTIMO = (DIAGONAL != 0) ? 3'd7 : 3'd3;

    estado_t                       estado;
    estado_t                       prox_estado;
    logic [2:0]                    k;
    logic [3:0]                    bloq;
    logic [COORD_WIDTH-1:0]        no_x;
    logic [COORD_WIDTH-1:0]        no_y;
    logic [COORD_WIDTH-1:0]        viz_x;
    logic [COORD_WIDTH-1:0]        viz_y;
    logic                          viz_diag;
    logic [ADDR_WIDTH-1:0]         mem_addr;

    logic signed [1:0]             dx;
    logic signed [1:0]             dy;
    logic signed [COORD_WIDTH:0]   dx_ext;
    logic signed [COORD_WIDTH:0]   dy_ext;
    logic signed [COORD_WIDTH:0]   cand_x;
    logic signed [COORD_WIDTH:0]   cand_y;
    logic                          fora;
    logic                          diag_rej;
    logic [ADDR_WIDTH-1:0]         addr_cand;

    always_comb begin
        dx = 2'sb00;
        dy = 2'sb00;
        case (k)
            3'd0: begin dx = 2'sb01; dy = 2'sb00; end
            3'd1: begin dx = 2'sb00; dy = 2'sb01; end
            3'd2: begin dx = 2'sb11; dy = 2'sb00; end
            3'd3: begin dx = 2'sb00; dy = 2'sb11; end
            3'd4: begin dx = 2'sb01; dy = 2'sb01; end
            3'd5: begin dx = 2'sb11; dy = 2'sb01; end
            3'd6: begin dx = 2'sb11; dy = 2'sb11; end
            default: begin dx = 2'sb01; dy = 2'sb11; end
        endcase
    end

    // One extra sign bit: -1 shows up as negative, and +1 past the top either
    // sets the sign bit (full-range grid) or exceeds the grid size.
    assign dx_ext = {{(COORD_WIDTH-1){dx[1]}}, dx};
    assign dy_ext = {{(COORD_WIDTH-1){dy[1]}}, dy};
    assign cand_x = $signed({1'b0, no_x}) + dx_ext;
    assign cand_y = $signed({1'b0, no_y}) + dy_ext;

    assign fora = cand_x[COORD_WIDTH] || (int'(cand_x[COORD_WIDTH-1:0]) >= GRID_X) ||
                  cand_y[COORD_WIDTH] || (int'(cand_y[COORD_WIDTH-1:0]) >= GRID_Y);

    assign addr_cand = ADDR_WIDTH'(int'(cand_y[COORD_WIDTH-1:0]) * GRID_X +
                                   int'(cand_x[COORD_WIDTH-1:0]));

    always_comb begin
        diag_rej = 1'b0;
        case (k)
            3'd4:    diag_rej = bloq[0] | bloq[1];
            3'd5:    diag_rej = bloq[2] | bloq[1];
            3'd6:    diag_rej = bloq[2] | bloq[3];
            3'd7:    diag_rej = bloq[0] | bloq[3];
            default: diag_rej = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= IDLE;
        end else begin
            estado <= prox_estado;
        end
    end

    always_comb begin
        prox_estado = estado;
        case (estado)
            IDLE:     if (expandir_in) prox_estado = GERAR;
            GERAR:    prox_estado = (fora || diag_rej) ? PROXIMO : LER;
            LER:      if (mem_ack_in) prox_estado = mem_obstaculo_in ? PROXIMO : ENTREGAR;
            ENTREGAR: if (viz_aceito_in) prox_estado = PROXIMO;
            PROXIMO:  prox_estado = (k == K_ULTIMO) ? PRONTO : GERAR;
            PRONTO:   prox_estado = IDLE;
            default:  prox_estado = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k        <= '0;
            bloq     <= '0;
            no_x     <= '0;
            no_y     <= '0;
            viz_x    <= '0;
            viz_y    <= '0;
            viz_diag <= 1'b0;
            mem_addr <= '0;
        end else begin
            case (estado)
                IDLE: begin
                    if (expandir_in) begin
                        no_x <= no_x_in;
                        no_y <= no_y_in;
                        k    <= '0;
                        bloq <= '0;
                    end
                end
                GERAR: begin
                    if (!k[2] && fora) begin
                        bloq[k[1:0]] <= 1'b1;
                    end
                    // Candidate is frozen on entry to LER and held through ENTREGAR.
                    if (prox_estado == LER) begin
                        viz_x    <= cand_x[COORD_WIDTH-1:0];
                        viz_y    <= cand_y[COORD_WIDTH-1:0];
                        viz_diag <= k[2];
                        mem_addr <= addr_cand;
                    end
                end
                LER: begin
                    if (mem_ack_in && mem_obstaculo_in && !k[2]) begin
                        bloq[k[1:0]] <= 1'b1;
                    end
                end
                PROXIMO: begin
                    if (k != K_ULTIMO) begin
                        k <= k + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ocupado_out    = (estado != IDLE);
        mem_req_out    = (estado == LER);
        viz_valido_out = (estado == ENTREGAR);
        lvv_pronto_out = (estado == PRONTO);
    end

    assign mem_addr_out     = mem_addr;
    assign viz_x_out        = viz_x;
    assign viz_y_out        = viz_y;
    assign viz_diagonal_out = viz_diag;

endmodule
